// File: rtl/soc_ctrl_pkg.sv
// rtl/soc_ctrl_pkg.sv - shared constants and types for the SoC control clocking blocks
package soc_ctrl_pkg;

  localparam int CLK_DIV_WIDTH = 8;

  typedef enum logic {
    RUN  = 1'b0,
    PEND = 1'b1
  } div_state_t;

endpackage

// File: rtl/soc_clk_divider.sv
// rtl/soc_clk_divider.sv - programmable integer clock divider with boundary-aligned ratio updates
module soc_clk_divider
  import soc_ctrl_pkg::*;
#(
  parameter int DIV_WIDTH = CLK_DIV_WIDTH,
  parameter int RESET_DIV = 1
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  input  logic                 en_i,
  input  logic [DIV_WIDTH-1:0] div_i,
  input  logic                 div_valid_i,
  output logic                 clk_en_o,
  output logic                 clk_o,
  output logic                 bypass_o,
  output logic                 busy_o
);

  localparam logic [DIV_WIDTH-1:0] W_ONE   = DIV_WIDTH'(1);
  localparam logic [DIV_WIDTH-1:0] RST_DIV = (RESET_DIV < 1) ? W_ONE : DIV_WIDTH'(RESET_DIV);

  // Ratio 0 is folded to 1 so the active ratio register never holds 0.
  function automatic logic [DIV_WIDTH-1:0] norm_div(input logic [DIV_WIDTH-1:0] d);
    return (d == '0) ? W_ONE : d;
  endfunction

  logic [DIV_WIDTH-1:0] r_cnt;
  logic [DIV_WIDTH-1:0] r_div;
  logic [DIV_WIDTH-1:0] r_pend_div;
  div_state_t           r_state;
  logic                 r_clk;
  logic                 r_bypass;

  logic [DIV_WIDTH-1:0] w_cnt_next;
  logic [DIV_WIDTH-1:0] w_div_next;
  logic [DIV_WIDTH-1:0] w_pend_next;
  logic [DIV_WIDTH-1:0] w_apply_val;
  div_state_t           w_state_next;
  logic                 w_clk_next;
  logic                 w_last;

  assign w_last = (r_cnt == (r_div - W_ONE));

  always_comb begin
    w_cnt_next   = r_cnt + W_ONE;
    w_div_next   = r_div;
    w_pend_next  = r_pend_div;
    w_state_next = r_state;
    // A strobe in the applying cycle overrides any older pending value.
    w_apply_val  = div_valid_i ? div_i : r_pend_div;

    if (!en_i || w_last) begin
      w_cnt_next   = '0;
      w_state_next = RUN;
      if (div_valid_i || (r_state == PEND)) begin
        w_div_next = norm_div(w_apply_val);
      end
    end else if (div_valid_i) begin
      w_pend_next  = div_i;
      w_state_next = PEND;
    end

    w_clk_next = en_i && (w_div_next > W_ONE) && (w_cnt_next < (w_div_next >> 1));
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_cnt      <= '0;
      r_div      <= RST_DIV;
      r_pend_div <= '0;
      r_state    <= RUN;
      r_clk      <= 1'b0;
      r_bypass   <= (RST_DIV == W_ONE);
    end else begin
      r_cnt      <= w_cnt_next;
      r_div      <= w_div_next;
      r_pend_div <= w_pend_next;
      r_state    <= w_state_next;
      r_clk      <= w_clk_next;
      r_bypass   <= (w_div_next == W_ONE);
    end
  end

  assign clk_en_o = w_last && en_i;
  assign clk_o    = r_clk;
  assign bypass_o = r_bypass;
  assign busy_o   = (r_state == PEND);

endmodule

// File: tb/tb_soc_clk_divider.sv
// tb/tb_soc_clk_divider.sv - directed self-checking bench for soc_clk_divider
module tb_soc_clk_divider;

  logic       HCLK = 1'b0;
  logic       HRESETn;
  logic       en_i;
  logic [7:0] div_i;
  logic       div_valid_i;
  logic       clk_en_o;
  logic       clk_o;
  logic       bypass_o;
  logic       busy_o;

  int tests_run = 0;
  int tests_failed = 0;

  soc_clk_divider #(.DIV_WIDTH(8), .RESET_DIV(1)) dut (
    .HCLK        (HCLK),
    .HRESETn     (HRESETn),
    .en_i        (en_i),
    .div_i       (div_i),
    .div_valid_i (div_valid_i),
    .clk_en_o    (clk_en_o),
    .clk_o       (clk_o),
    .bypass_o    (bypass_o),
    .busy_o      (busy_o)
  );

  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag, input string field, input logic obs, input logic exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s.%s observed=%0b expected=%0b", tag, field, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic e_en, input logic e_clk,
                         input logic e_busy, input logic e_byp);
    chk(tag, "clk_en", clk_en_o, e_en);
    chk(tag, "clk",    clk_o,    e_clk);
    chk(tag, "busy",   busy_o,   e_busy);
    chk(tag, "bypass", bypass_o, e_byp);
  endtask

  // Drive one cycle of inputs, clock it in, check state after the edge.
  task automatic row(input string tag, input logic en, input logic v, input logic [7:0] d,
                     input logic e_en, input logic e_clk, input logic e_busy, input logic e_byp);
    en_i        = en;
    div_valid_i = v;
    div_i       = d;
    @(posedge HCLK);
    #1;
    div_valid_i = 1'b0;
    chk_all(tag, e_en, e_clk, e_busy, e_byp);
  endtask

  initial begin
    HRESETn     = 1'b0;
    en_i        = 1'b0;
    div_i       = 8'd0;
    div_valid_i = 1'b0;
    #12;
    chk_all("reset", 1'b0, 1'b0, 1'b0, 1'b1);
    HRESETn = 1'b1;

    // N=1 after reset: strobe every cycle, bypass
    row("t1_c0", 1, 0, 0, 1, 0, 0, 1);
    row("t1_c1", 1, 0, 0, 1, 0, 0, 1);
    row("t1_c2", 1, 0, 0, 1, 0, 0, 1);

    // N=4 applied at a RUN boundary
    row("t2_c0", 1, 1, 4, 0, 1, 0, 0);
    row("t2_c1", 1, 0, 0, 0, 1, 0, 0);
    row("t2_c2", 1, 0, 0, 0, 0, 0, 0);
    row("t2_c3", 1, 0, 0, 1, 0, 0, 0);
    row("t2_c4", 1, 0, 0, 0, 1, 0, 0);
    row("t2_c5", 1, 0, 0, 0, 1, 0, 0);
    row("t2_c6", 1, 0, 0, 0, 0, 0, 0);
    row("t2_c7", 1, 0, 0, 1, 0, 0, 0);

    // N=8, strobe 3 at cnt=2, applied at the wrap
    row("t3_n8", 1, 1, 8, 0, 1, 0, 0);
    row("t3_c1", 1, 0, 0, 0, 1, 0, 0);
    row("t3_c2", 1, 0, 0, 0, 1, 0, 0);
    row("t3_c3", 1, 1, 3, 0, 1, 1, 0);
    row("t3_c4", 1, 0, 0, 0, 0, 1, 0);
    row("t3_c5", 1, 0, 0, 0, 0, 1, 0);
    row("t3_c6", 1, 0, 0, 0, 0, 1, 0);
    row("t3_c7", 1, 0, 0, 1, 0, 1, 0);
    row("t3_a0", 1, 0, 0, 0, 1, 0, 0);
    row("t3_a1", 1, 0, 0, 0, 0, 0, 0);
    row("t3_a2", 1, 0, 0, 1, 0, 0, 0);

    // N=8, pend 5 at cnt=1, overwrite with 2 at cnt=4
    row("t4_n8", 1, 1, 8, 0, 1, 0, 0);
    row("t4_c1", 1, 0, 0, 0, 1, 0, 0);
    row("t4_c2", 1, 1, 5, 0, 1, 1, 0);
    row("t4_c3", 1, 0, 0, 0, 1, 1, 0);
    row("t4_c4", 1, 0, 0, 0, 0, 1, 0);
    row("t4_c5", 1, 1, 2, 0, 0, 1, 0);
    row("t4_c6", 1, 0, 0, 0, 0, 1, 0);
    row("t4_c7", 1, 0, 0, 1, 0, 1, 0);
    row("t4_a0", 1, 0, 0, 0, 1, 0, 0);
    row("t4_a1", 1, 0, 0, 1, 0, 0, 0);
    row("t4_a2", 1, 0, 0, 0, 1, 0, 0);

    // N=6, drop enable at cnt=3, ratio 0 while disabled, re-enable
    row("t5_c1", 1, 0, 0, 1, 0, 0, 0);
    row("t5_n6", 1, 1, 6, 0, 1, 0, 0);
    row("t5_c1b", 1, 0, 0, 0, 1, 0, 0);
    row("t5_c2", 1, 0, 0, 0, 1, 0, 0);
    row("t5_c3", 1, 0, 0, 0, 0, 0, 0);
    row("t5_off", 0, 0, 0, 0, 0, 0, 0);
    row("t5_div0", 0, 1, 0, 0, 0, 0, 1);
    row("t5_on0", 1, 0, 0, 1, 0, 0, 1);
    row("t5_on1", 1, 0, 0, 1, 0, 0, 1);

    // N=255 across the wrap, then async reset with an update pending
    row("t6_n255", 1, 1, 255, 0, 1, 0, 0);
    en_i = 1'b1;
    repeat (253) @(posedge HCLK);
    #1;
    row("t6_c254", 1, 0, 0, 1, 0, 0, 0);
    row("t6_wrap", 1, 0, 0, 0, 1, 0, 0);
    row("t6_c1",   1, 0, 0, 0, 1, 0, 0);
    row("t6_pend", 1, 1, 7, 0, 1, 1, 0);
    row("t6_c3",   1, 0, 0, 0, 1, 1, 0);
    HRESETn = 1'b0;
    en_i    = 1'b0;
    #2;
    chk_all("t6_rst", 1'b0, 1'b0, 1'b0, 1'b1);
    #2;
    HRESETn = 1'b1;
    row("t6_r0", 1, 0, 0, 1, 0, 0, 1);
    row("t6_r1", 1, 0, 0, 1, 0, 0, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
